// File: rtl/ctrl_sequencer_if.sv
// Control bundle between ctrl_sequencer (master) and the datapath/fetch side (slave):
// instruction fields in, CTRL_* decode, PC hold, halt flag and performance counters out.
interface ctrl_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             START;
  logic [3:0]       opcode;
  logic             fcode;
  logic             CTRL_branch_rel_nz;
  logic             CTRL_branch_rel_z;
  logic             CTRL_branch_abs;
  logic             CTRL_reg_write_en;
  logic             CTRL_reg_sel;
  logic             CTRL_lut_in;
  logic             CTRL_mem_to_reg;
  logic             CTRL_alu_src;
  logic             CTRL_alu_sc_in;
  logic             CTRL_read_mem;
  logic             CTRL_write_mem;
  logic [2:0]       CTRL_alu_op;
  logic             PC_HOLD;
  logic             DONE_HALT;
  logic [CNT_W-1:0] RETIRED;
  logic [CNT_W-1:0] STALLS;

  modport master (
    input  START, opcode, fcode,
    output CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
           CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
           CTRL_read_mem, CTRL_write_mem, CTRL_alu_op, PC_HOLD, DONE_HALT, RETIRED, STALLS
  );

  modport slave (
    output START, opcode, fcode,
    input  CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
           CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
           CTRL_read_mem, CTRL_write_mem, CTRL_alu_op, PC_HOLD, DONE_HALT, RETIRED, STALLS
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit: decodes opcode/fcode and sequences IDLE/RUN/LDWAIT/HALT.
// Define CTRL_PERF_CNT_EN to build the saturating RETIRED/STALLS performance counters.
module ctrl_sequencer #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               reset,
  ctrl_sequencer_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, LDWAIT, HALT} state_e;

  localparam logic [2:0] LAST_WAIT = (LOAD_LAT == 0) ? 3'd0 : 3'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       done_q;

  logic       br_nz, br_z, br_abs, reg_we, reg_sel, lut_in;
  logic       mem_to_reg, alu_src, alu_sc_in, read_mem, write_mem, pc_hold;
  logic [2:0] alu_op;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    br_nz      = 1'b0;
    br_z       = 1'b0;
    br_abs     = 1'b0;
    reg_we     = 1'b0;
    reg_sel    = 1'b0;
    lut_in     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_sc_in  = 1'b0;
    read_mem   = 1'b0;
    write_mem  = 1'b0;
    pc_hold    = 1'b0;
    alu_op     = 3'd0;
    case (state_q)
      IDLE: ;
      RUN: begin
        case (bus.opcode)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            alu_op = bus.opcode[2:0];
            reg_we = 1'b1;
            if (bus.opcode == 4'd5 || bus.opcode == 4'd6) alu_sc_in = bus.fcode;
          end
          4'd7: begin
            alu_src = 1'b1;
            reg_we  = 1'b1;
          end
          4'd8: begin
            read_mem   = 1'b1;
            mem_to_reg = 1'b1;
            if (LOAD_LAT == 0) begin
              reg_we = 1'b1;
            end else begin
              pc_hold = 1'b1;
              state_d = LDWAIT;
              wcnt_d  = 3'd0;
            end
          end
          4'd9:  write_mem = 1'b1;
          4'd10: begin br_nz = 1'b1; alu_op = 3'd1; end
          4'd11: begin br_z  = 1'b1; alu_op = 3'd1; end
          4'd12: br_abs = 1'b1;
          4'd13: begin br_abs = 1'b1; lut_in = 1'b1; end
          4'd14: begin reg_sel = 1'b1; reg_we = 1'b1; end
          default: begin
            if (bus.fcode) begin
              pc_hold = 1'b1;
              state_d = HALT;
            end
          end
        endcase
      end
      LDWAIT: begin
        // Decode stays latched as LD; a START here abandons the load without writing.
        read_mem   = 1'b1;
        mem_to_reg = 1'b1;
        if (wcnt_q == LAST_WAIT && !bus.START) begin
          reg_we  = 1'b1;
          wcnt_d  = 3'd0;
          state_d = RUN;
        end else begin
          pc_hold = 1'b1;
          wcnt_d  = wcnt_q + 3'd1;
        end
      end
      default: pc_hold = 1'b1;
    endcase
    if (bus.START) begin
      state_d = RUN;
      wcnt_d  = 3'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      done_q  <= (state_d == HALT);
    end
  end

`ifdef CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] retired_q, stalls_q;
  logic             retire, stall;

  assign retire = (state_q == RUN && !(bus.opcode == 4'd8 && LOAD_LAT != 0)) ||
                  (state_q == LDWAIT && reg_we);
  assign stall  = pc_hold && (state_q == RUN || state_q == LDWAIT);

  always_ff @(posedge CLK) begin
    if (reset || bus.START) begin
      retired_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (retire && !(&retired_q)) retired_q <= retired_q + CNT_ONE;
      if (stall && !(&stalls_q))   stalls_q  <= stalls_q + CNT_ONE;
    end
  end

  assign bus.RETIRED = retired_q;
  assign bus.STALLS  = stalls_q;
`else
  assign bus.RETIRED = '0;
  assign bus.STALLS  = '0;
`endif

  assign bus.CTRL_branch_rel_nz = br_nz;
  assign bus.CTRL_branch_rel_z  = br_z;
  assign bus.CTRL_branch_abs    = br_abs;
  assign bus.CTRL_reg_write_en  = reg_we;
  assign bus.CTRL_reg_sel       = reg_sel;
  assign bus.CTRL_lut_in        = lut_in;
  assign bus.CTRL_mem_to_reg    = mem_to_reg;
  assign bus.CTRL_alu_src       = alu_src;
  assign bus.CTRL_alu_sc_in     = alu_sc_in;
  assign bus.CTRL_read_mem      = read_mem;
  assign bus.CTRL_write_mem     = write_mem;
  assign bus.CTRL_alu_op        = alu_op;
  assign bus.PC_HOLD            = pc_hold;
  assign bus.DONE_HALT          = done_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer (LOAD_LAT=2): directed scenarios plus a randomized
// instruction stream checked against a cycle-level instruction/load-latency model.
module tb_ctrl_sequencer;

  localparam int unsigned LL    = 2;
  localparam int unsigned CNT_W = 16;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Observation vector bit positions
  localparam int B_BNZ = 15, B_BZ = 14, B_ABS = 13, B_RWE = 12, B_RSEL = 11, B_LUT = 10;
  localparam int B_M2R = 9, B_SRC = 8, B_SC = 7, B_RD = 6, B_WR = 5, B_HOLD = 1, B_DONE = 0;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  ctrl_sequencer_if #(.CNT_W(CNT_W)) bus ();

  ctrl_sequencer #(.LOAD_LAT(LL), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [15:0] obs;
  assign obs = {bus.CTRL_branch_rel_nz, bus.CTRL_branch_rel_z, bus.CTRL_branch_abs,
                bus.CTRL_reg_write_en, bus.CTRL_reg_sel, bus.CTRL_lut_in, bus.CTRL_mem_to_reg,
                bus.CTRL_alu_src, bus.CTRL_alu_sc_in, bus.CTRL_read_mem, bus.CTRL_write_mem,
                bus.CTRL_alu_op, bus.PC_HOLD, bus.DONE_HALT};

  int checks = 0;
  int passes = 0;

  // Expected RUN-cycle control vector for one instruction, from the decode table.
  function automatic logic [15:0] dec(input logic [3:0] op, input logic f);
    logic [15:0] v;
    v = '0;
    if (op <= 4'd6) begin
      v[4:2]   = op[2:0];
      v[B_RWE] = 1'b1;
      if (op == 4'd5 || op == 4'd6) v[B_SC] = f;
    end else begin
      case (op)
        4'd7:  begin v[B_SRC] = 1'b1; v[B_RWE] = 1'b1; end
        4'd8:  begin
          v[B_RD] = 1'b1; v[B_M2R] = 1'b1;
          if (LL == 0) v[B_RWE] = 1'b1; else v[B_HOLD] = 1'b1;
        end
        4'd9:  v[B_WR] = 1'b1;
        4'd10: begin v[B_BNZ] = 1'b1; v[4:2] = 3'd1; end
        4'd11: begin v[B_BZ] = 1'b1; v[4:2] = 3'd1; end
        4'd12: v[B_ABS] = 1'b1;
        4'd13: begin v[B_ABS] = 1'b1; v[B_LUT] = 1'b1; end
        4'd14: begin v[B_RSEL] = 1'b1; v[B_RWE] = 1'b1; end
        default: v[B_HOLD] = f;
      endcase
    end
    return v;
  endfunction

  // Expected vector in a load wait cycle; the final one writes and releases the PC.
  function automatic logic [15:0] ldv(input bit last);
    logic [15:0] v;
    v = '0;
    v[B_RD]  = 1'b1;
    v[B_M2R] = 1'b1;
    if (last) v[B_RWE] = 1'b1; else v[B_HOLD] = 1'b1;
    return v;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    bus.START  = 1'b1;
    bus.opcode = 4'd15;
    bus.fcode  = 1'b0;
    cyc();
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.START  = 1'b1;
    bus.opcode = 4'd8;
    bus.fcode  = 1'b1;
    cyc();
    cyc();
    reset     = 1'b0;
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 4'($urandom);
      bus.fcode  = 1'($urandom);
      mid();
      checks++;
      if (obs !== 16'h0000) $display("FAIL reset_idle cyc%0d: got %h want 0000", i, obs);
      else passes++;
      cyc();
    end
    checks++;
    if (bus.RETIRED !== '0 || bus.STALLS !== '0)
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.RETIRED, bus.STALLS);
    else passes++;
  endtask

  task automatic test_addi();
    logic f;
    pulse_start();
    f = 1'($urandom);
    bus.opcode = 4'd7;
    bus.fcode  = f;
    mid();
    checks++;
    if (obs !== dec(4'd7, f)) $display("FAIL addi: got %h want %h", obs, dec(4'd7, f));
    else passes++;
    cyc();
  endtask

  task automatic test_load();
    pulse_start();
    bus.opcode = 4'd8;
    bus.fcode  = 1'($urandom);
    mid();
    checks++;
    if (obs !== dec(4'd8, 1'b0)) $display("FAIL load_c0: got %h want %h", obs, dec(4'd8, 1'b0));
    else passes++;
    cyc();
    for (int k = 1; k <= int'(LL); k++) begin
      bus.opcode = 4'($urandom);
      mid();
      checks++;
      if (obs !== ldv(k == int'(LL)))
        $display("FAIL load_c%0d: got %h want %h", k, obs, ldv(k == int'(LL)));
      else passes++;
      cyc();
    end
    bus.opcode = 4'd15;
    bus.fcode  = 1'b0;
    mid();
    checks++;
    if (bus.STALLS !== (PERF ? CNT_W'(LL) : '0) || bus.RETIRED !== (PERF ? CNT_W'(1) : '0))
      $display("FAIL load_cnt: got stalls=%0d retired=%0d want %0d/%0d", bus.STALLS,
               bus.RETIRED, PERF ? LL : 0, PERF ? 1 : 0);
    else passes++;
    cyc();
  endtask

  task automatic test_halt();
    pulse_start();
    bus.opcode = 4'd15;
    bus.fcode  = 1'b1;
    mid();
    checks++;
    if (obs !== dec(4'd15, 1'b1)) $display("FAIL halt_decode: got %h want %h", obs, dec(4'd15, 1'b1));
    else passes++;
    cyc();
    for (int i = 0; i < 10; i++) begin
      bus.opcode = 4'($urandom);
      bus.fcode  = 1'($urandom);
      mid();
      checks++;
      if (obs !== 16'h0003) $display("FAIL halt_hold cyc%0d: got %h want 0003", i, obs);
      else passes++;
      cyc();
    end
    checks++;
    if (bus.RETIRED !== (PERF ? CNT_W'(1) : '0))
      $display("FAIL halt_retired: got %0d want %0d", bus.RETIRED, PERF ? 1 : 0);
    else passes++;
    bus.START = 1'b1;
    cyc();
    bus.START  = 1'b0;
    bus.opcode = 4'd1;
    bus.fcode  = 1'b0;
    mid();
    checks++;
    if (obs !== dec(4'd1, 1'b0)) $display("FAIL halt_restart: got %h want %h", obs, dec(4'd1, 1'b0));
    else passes++;
    cyc();
  endtask

  task automatic test_load_abort();
    pulse_start();
    bus.opcode = 4'd8;
    cyc();
    bus.opcode = 4'($urandom);
    cyc();
    bus.START = 1'b1;
    mid();
    checks++;
    if (obs[B_RWE] !== 1'b0 || obs[B_WR] !== 1'b0)
      $display("FAIL abort_nowrite: got rwe=%b wr=%b want 0/0", obs[B_RWE], obs[B_WR]);
    else passes++;
    cyc();
    bus.START  = 1'b0;
    bus.opcode = 4'd7;
    bus.fcode  = 1'b0;
    mid();
    checks++;
    if (obs !== dec(4'd7, 1'b0)) $display("FAIL abort_run: got %h want %h", obs, dec(4'd7, 1'b0));
    else passes++;
    checks++;
    if (bus.RETIRED !== '0) $display("FAIL abort_retired: got %0d want 0", bus.RETIRED);
    else passes++;
    cyc();
  endtask

  task automatic test_sequence();
    logic [3:0] ops [7];
    logic f;
    ops = '{4'd0, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      f = (i == 6) ? 1'b1 : 1'($urandom);
      bus.opcode = ops[i];
      bus.fcode  = f;
      mid();
      checks++;
      if (obs !== dec(ops[i], f)) $display("FAIL seq op%0d: got %h want %h", ops[i], obs, dec(ops[i], f));
      else passes++;
      cyc();
    end
    mid();
    checks++;
    if (bus.RETIRED !== (PERF ? CNT_W'(7) : '0) || bus.STALLS !== (PERF ? CNT_W'(1) : '0))
      $display("FAIL seq_cnt: got retired=%0d stalls=%0d want %0d/%0d", bus.RETIRED,
               bus.STALLS, PERF ? 7 : 0, PERF ? 1 : 0);
    else passes++;
    cyc();
  endtask

  // Random stream of non-halting instructions; model tracks remaining load cycles.
  task automatic test_random();
    int pend = 0;
    int retired = 0;
    int stalls = 0;
    logic [3:0] op;
    logic f;
    logic [15:0] exp;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom);
      f  = 1'($urandom);
      if (op == 4'd15) f = 1'b0;
      bus.opcode = op;
      bus.fcode  = f;
      if (pend > 0) begin
        exp = ldv(pend == 1);
        if (pend == 1) retired++; else stalls++;
        pend--;
      end else begin
        exp = dec(op, f);
        if (op == 4'd8 && LL > 0) begin
          pend = int'(LL);
          stalls++;
        end else begin
          retired++;
        end
      end
      mid();
      checks++;
      if (obs !== exp) $display("FAIL rand cyc%0d op%0d: got %h want %h", i, op, obs, exp);
      else passes++;
      checks++;
      if (obs[B_RWE] && obs[B_WR]) $display("FAIL rand_excl cyc%0d: got rwe=1 wr=1 want not both", i);
      else passes++;
      cyc();
    end
    while (pend > 0) begin
      bus.opcode = 4'($urandom);
      if (pend == 1) retired++; else stalls++;
      mid();
      checks++;
      if (obs !== ldv(pend == 1)) $display("FAIL rand_tail: got %h want %h", obs, ldv(pend == 1));
      else passes++;
      pend--;
      cyc();
    end
    bus.opcode = 4'd15;
    bus.fcode  = 1'b0;
    mid();
    checks++;
    if (bus.RETIRED !== (PERF ? CNT_W'(retired) : '0) || bus.STALLS !== (PERF ? CNT_W'(stalls) : '0))
      $display("FAIL rand_cnt: got retired=%0d stalls=%0d want %0d/%0d", bus.RETIRED,
               bus.STALLS, PERF ? retired : 0, PERF ? stalls : 0);
    else passes++;
    cyc();
  endtask

  initial begin
    reset      = 1'b1;
    bus.START  = 1'b0;
    bus.opcode = 4'd0;
    bus.fcode  = 1'b0;
    #1;
    test_reset();
    test_addi();
    test_load();
    test_halt();
    test_load_abort();
    test_sequence();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
